// File: rtl/mem_access_unit.sv
// mem_access_unit: turns CPU byte/half/word load/store requests into
// word-aligned data_memory transactions. Sub-word stores are performed as
// read-modify-write; loads are lane-extracted and sign/zero-extended.
module mem_access_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t state, state_d;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_d;

  // Request fields captured at acceptance
  logic              lat_write, lat_write_d;
  logic              lat_signed, lat_signed_d;
  logic [1:0]        lat_size, lat_size_d;
  logic [1:0]        lat_off, lat_off_d;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_d;

  // Next values of the registered outputs
  logic              req_ready_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic              resp_error_d;
  logic [DATA_W-1:0] mem_address_d;
  logic [DATA_W-1:0] mem_write_data_d;
  logic              mem_write_d;
  logic              mem_read_d;

  logic              req_fire;
  logic              req_illegal;

  // Illegal size or misaligned half/word access
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the addressed lane of a word and extend it to 32 bits
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] size,
                                                     input logic sgn,
                                                     input logic [1:0] off);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the read word with store data
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] size,
                                                    input logic [1:0] off,
                                                    input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign req_fire    = req_valid && req_ready;
  assign req_illegal = is_illegal(req_size, req_address[1:0]);

  // Next-state, captured fields and next registered outputs
  always_comb begin
    state_d          = state;
    rd_cnt_d         = rd_cnt;
    lat_write_d      = lat_write;
    lat_signed_d     = lat_signed;
    lat_size_d       = lat_size;
    lat_off_d        = lat_off;
    lat_wdata_d      = lat_wdata;
    resp_rdata_d     = resp_rdata;
    resp_error_d     = resp_error;
    mem_address_d    = mem_address;
    mem_write_data_d = mem_write_data;

    case (state)
      IDLE: begin
        if (req_fire) begin
          lat_write_d  = req_write;
          lat_signed_d = req_signed;
          lat_size_d   = req_size;
          lat_off_d    = req_address[1:0];
          lat_wdata_d  = req_wdata;
          rd_cnt_d     = '0;
          resp_rdata_d = '0;
          resp_error_d = 1'b0;
          if (req_illegal) begin
            resp_error_d = 1'b1;
            state_d      = DONE;
          end else begin
            mem_address_d = {req_address[31:2], 2'b00};
            if (req_write && (req_size == SZ_WORD)) begin
              mem_write_data_d = req_wdata;
              state_d          = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (rd_cnt == RD_LAST) begin
          if (lat_write) begin
            mem_write_data_d = store_merge(mem_read_data, lat_size, lat_off, lat_wdata);
            state_d          = WR;
          end else begin
            resp_rdata_d = load_extract(mem_read_data, lat_size, lat_signed, lat_off);
            state_d      = DONE;
          end
        end else begin
          rd_cnt_d = rd_cnt + CNT_W'(1);
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Moore strobes/handshake registered from the upcoming state
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    mem_read_d   = (state_d == RD);
    mem_write_d  = (state_d == WR);
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rd_cnt         <= '0;
      lat_write      <= 1'b0;
      lat_signed     <= 1'b0;
      lat_size       <= 2'b00;
      lat_off        <= 2'b00;
      lat_wdata      <= '0;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      MemWrite       <= 1'b0;
      MemRead        <= 1'b0;
    end else begin
      state          <= state_d;
      rd_cnt         <= rd_cnt_d;
      lat_write      <= lat_write_d;
      lat_signed     <= lat_signed_d;
      lat_size       <= lat_size_d;
      lat_off        <= lat_off_d;
      lat_wdata      <= lat_wdata_d;
      req_ready      <= req_ready_d;
      resp_valid     <= resp_valid_d;
      resp_rdata     <= resp_rdata_d;
      resp_error     <= resp_error_d;
      mem_address    <= mem_address_d;
      mem_write_data <= mem_write_data_d;
      MemWrite       <= mem_write_d;
      MemRead        <= mem_read_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: two instances (READ_LATENCY 1 and 3),
// each backed by a small word memory model.
module tb_mem_access_unit;

  localparam int N = 2;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
    logic [31:0] waddr;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst         [N];
  logic        req_valid   [N];
  logic        req_ready   [N];
  logic        req_write   [N];
  logic [1:0]  req_size    [N];
  logic        req_signed  [N];
  logic [31:0] req_address [N];
  logic [31:0] req_wdata   [N];
  logic        resp_valid  [N];
  logic [31:0] resp_rdata  [N];
  logic        resp_error  [N];
  logic [31:0] mem_address [N];
  logic [31:0] mem_wdata   [N];
  logic        mem_we      [N];
  logic        mem_re      [N];
  logic [31:0] mem_rdata   [N];
  logic [31:0] mem         [N][16];

  exp_t q0[$];
  exp_t q1[$];

  int vecs = 0, errs = 0, cyc = 0, tmo = 0, tmo_seen = 0;
  bit busy [N];
  int acc [N], gap [N], nrd [N], nwr [N];
  logic [31:0] wdat [N], wadr [N];

  always #5 clk = ~clk;

  mem_access_unit #(.READ_LATENCY(1)) u_dut_l1 (
    .clock(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_address(req_address[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_error(resp_error[0]), .mem_address(mem_address[0]), .mem_write_data(mem_wdata[0]),
    .MemWrite(mem_we[0]), .MemRead(mem_re[0]), .mem_read_data(mem_rdata[0]));

  mem_access_unit #(.READ_LATENCY(3)) u_dut_l3 (
    .clock(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_address(req_address[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_error(resp_error[1]), .mem_address(mem_address[1]), .mem_write_data(mem_wdata[1]),
    .MemWrite(mem_we[1]), .MemRead(mem_re[1]), .mem_read_data(mem_rdata[1]));

  // data_memory models: combinational read, write on the MemWrite edge
  for (genvar g = 0; g < N; g++) begin : g_mem
    assign mem_rdata[g] = mem[g][mem_address[g][5:2]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (mem_we[i]) mem[i][mem_address[i][5:2]] <= mem_wdata[i];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s (vec %0d): got %h, expected %h", nm, id, act, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] rdata, input logic err, input int lat,
                              input int nr, input int nw, input logic [31:0] wd, input logic [31:0] wa,
                              input int gp);
    exp_t e;
    e.id = id; e.rdata = rdata; e.err = err; e.lat = lat; e.nrd = nr; e.nwr = nw;
    e.wdata = wd; e.waddr = wa; e.gap = gp;
    return e;
  endfunction

  // Monitor: acceptance seen on the rising edge, everything else checked on the falling edge
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      for (int i = 0; i < N; i++)
        if (!rst[i] && req_valid[i] && req_ready[i]) begin
          gap[i]  = cyc + 1 - acc[i];
          acc[i]  = cyc + 1;
          busy[i] = 1'b1;
        end
    end else begin
      if (tmo != tmo_seen) begin
        check("timeout", -1, 32'(tmo), 32'(tmo_seen));
        tmo_seen = tmo;
      end
      for (int i = 0; i < N; i++) begin
        if (rst[i]) begin
          check("rst_ready", i, 32'(req_ready[i]), 0);
          check("rst_memread", i, 32'(mem_re[i]), 0);
          check("rst_memwrite", i, 32'(mem_we[i]), 0);
          check("rst_resp_valid", i, 32'(resp_valid[i]), 0);
          busy[i] = 1'b0; nrd[i] = 0; nwr[i] = 0;
        end else begin
          if (mem_re[i]) nrd[i]++;
          if (mem_we[i]) begin
            nwr[i]++;
            wdat[i] = mem_wdata[i];
            wadr[i] = mem_address[i];
          end
          if (mem_re[i] && mem_we[i]) check("strobe_overlap", i, 1, 0);
          if (busy[i]) check("ready_while_busy", i, 32'(req_ready[i]), 0);
          if (resp_valid[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              check("unexpected_resp", i, 1, 0);
            end else begin
              exp_t e;
              if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
              check("resp_rdata", e.id, resp_rdata[i], e.rdata);
              check("resp_error", e.id, 32'(resp_error[i]), 32'(e.err));
              check("latency", e.id, 32'(cyc - acc[i] + 1), 32'(e.lat));
              check("memread_cycles", e.id, 32'(nrd[i]), 32'(e.nrd));
              check("memwrite_cycles", e.id, 32'(nwr[i]), 32'(e.nwr));
              if (e.nwr > 0) begin
                check("mem_write_data", e.id, wdat[i], e.wdata);
                check("mem_address", e.id, wadr[i], e.waddr);
              end
              if (e.gap > 0) check("accept_gap", e.id, 32'(gap[i]), 32'(e.gap));
            end
            busy[i] = 1'b0; nrd[i] = 0; nwr[i] = 0;
          end
        end
      end
    end
  end

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Push the expectation, present the request and return just after its acceptance edge
  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input exp_t e, input bit hold);
    bit ok = 1'b0;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    req_write[d] = wr; req_size[d] = sz; req_signed[d] = sg;
    req_address[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (req_ready[d]) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      tmo++;
      if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    end
    if (!hold || !ok) req_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int k = 0;
    while (k < 100 && !(qsize(d) == 0 && !busy[d])) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) tmo++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_size[i] = 2'b00;
      req_signed[i] = 1'b0; req_address[i] = '0; req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    // READ_LATENCY = 1 instance
    issue(0, 1, W, 0, 32'h00, 32'h0000000A, mk(1, 0, 0, 2, 0, 1, 32'h0000000A, 32'h0, 0), 0); wait_done(0);
    issue(0, 0, W, 0, 32'h00, 32'h0, mk(2, 32'h0000000A, 0, 2, 1, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 1, W, 0, 32'h04, 32'h11223344, mk(3, 0, 0, 2, 0, 1, 32'h11223344, 32'h4, 0), 0); wait_done(0);
    issue(0, 1, B, 0, 32'h06, 32'h123456AB, mk(4, 0, 0, 3, 1, 1, 32'h11AB3344, 32'h4, 0), 0); wait_done(0);
    issue(0, 1, W, 0, 32'h08, 32'h8000F0FF, mk(5, 0, 0, 2, 0, 1, 32'h8000F0FF, 32'h8, 0), 0); wait_done(0);
    issue(0, 0, B, 1, 32'h08, 32'h0, mk(6, 32'hFFFFFFFF, 0, 2, 1, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 0, B, 0, 32'h08, 32'h0, mk(7, 32'h000000FF, 0, 2, 1, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 0, H, 1, 32'h0A, 32'h0, mk(8, 32'hFFFF8000, 0, 2, 1, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 0, H, 0, 32'h08, 32'h0, mk(9, 32'h0000F0FF, 0, 2, 1, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 0, B, 1, 32'h0B, 32'h0, mk(10, 32'hFFFFFF80, 0, 2, 1, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 0, B, 0, 32'h09, 32'h0, mk(11, 32'h000000F0, 0, 2, 1, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 1, H, 0, 32'h0A, 32'hDEAD1234, mk(12, 0, 0, 3, 1, 1, 32'h1234F0FF, 32'h8, 0), 0); wait_done(0);
    issue(0, 0, W, 1, 32'h08, 32'h0, mk(13, 32'h1234F0FF, 0, 2, 1, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 0, W, 0, 32'h02, 32'h0, mk(14, 0, 1, 1, 0, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 1, H, 0, 32'h03, 32'hFFFF, mk(15, 0, 1, 1, 0, 0, 0, 0, 0), 0); wait_done(0);
    issue(0, 0, X, 0, 32'h00, 32'h0, mk(16, 0, 1, 1, 0, 0, 0, 0, 0), 0); wait_done(0);

    // Reset during the read phase of a byte store: no write, no response
    issue(0, 1, B, 0, 32'h04, 32'h00000055, mk(17, 0, 0, 3, 1, 1, 32'h11AB3355, 32'h4, 0), 0);
    #3;
    rst[0] = 1'b1;
    q0.delete();
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    issue(0, 0, W, 0, 32'h04, 32'h0, mk(18, 32'h11AB3344, 0, 2, 1, 0, 0, 0, 0), 0); wait_done(0);

    // READ_LATENCY = 3 instance
    issue(1, 1, W, 0, 32'h10, 32'hCAFEF00D, mk(20, 0, 0, 2, 0, 1, 32'hCAFEF00D, 32'h10, 0), 0); wait_done(1);
    issue(1, 0, W, 0, 32'h10, 32'h0, mk(21, 32'hCAFEF00D, 0, 4, 3, 0, 0, 0, 0), 1);
    issue(1, 0, W, 0, 32'h10, 32'h0, mk(22, 32'hCAFEF00D, 0, 4, 3, 0, 0, 0, 5), 0); wait_done(1);
    issue(1, 1, B, 0, 32'h13, 32'h00000077, mk(23, 0, 0, 5, 3, 1, 32'h77FEF00D, 32'h10, 0), 0); wait_done(1);
    issue(1, 0, H, 1, 32'h12, 32'h0, mk(24, 32'h000077FE, 0, 4, 3, 0, 0, 0, 0), 0); wait_done(1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
